// File: rtl/id_decode_hazard.sv
// id_decode_hazard: decode stage of the 32-bit MIPS pipeline, sitting between IF and EX.
// It decodes each accepted instruction into register fields and classifies it by type.
// It keeps a HAZ_DEPTH-deep window of the destinations of older instructions still in flight.
// A source that matches an in-flight destination either stalls the stage or is forwarded.
// The output register uses a valid/ready handshake.
// After a HALT is accepted the stage stops accepting instructions until reset.
// Optional feature macro: ID_FORWARD_EN turns on the operand-forwarding selects.
// Without it, every match stalls and the forwarding selects are tied to zero.
// Only XLEN = 32 and HAZ_DEPTH in 1..3 are meaningful.
module id_decode_hazard #(
    parameter int XLEN      = 32,
    parameter int RA_W      = 5,
    parameter int HAZ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      out_opcode,
    output logic [1:0]      out_type,
    output logic [RA_W-1:0] out_rs,
    output logic [RA_W-1:0] out_rt,
    output logic [RA_W-1:0] out_rd,
    output logic [4:0]      out_sa,
    output logic [5:0]      out_funct,
    output logic [15:0]     out_imm,
    output logic [25:0]     out_jaddr,
    output logic            out_wb_en,
    output logic [RA_W-1:0] out_wb_reg,
    output logic            out_illegal,
    output logic [1:0]      fwd_rs_sel,
    output logic [1:0]      fwd_rt_sel,
    output logic            stall,
    output logic            halted
);

`ifdef ID_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam logic [1:0] TYPE_R    = 2'd0;
    localparam logic [1:0] TYPE_J    = 2'd1;
    localparam logic [1:0] TYPE_HALT = 2'd2;
    localparam logic [1:0] TYPE_I    = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    // Raw fields of the instruction presented by IF
    logic [5:0]      dec_opcode;
    logic [RA_W-1:0] dec_rs;
    logic [RA_W-1:0] dec_rt;
    logic [RA_W-1:0] dec_rd;

    assign dec_opcode = in_instr[31:26];
    assign dec_rs     = RA_W'(in_instr[25:21]);
    assign dec_rt     = RA_W'(in_instr[20:16]);
    assign dec_rd     = RA_W'(in_instr[15:11]);

    // Classification results
    logic [1:0]      dec_type;
    logic            dec_use_rs;
    logic            dec_use_rt;
    logic            dec_has_dst;
    logic [RA_W-1:0] dec_dst;
    logic            dec_load;
    logic            dec_illegal;
    logic            dec_wb_en;
    logic [RA_W-1:0] dec_wb_reg;

    // Classify the opcode: type, which sources are read, and which register is written
    always_comb begin
        dec_type    = TYPE_I;
        dec_use_rs  = 1'b0;
        dec_use_rt  = 1'b0;
        dec_has_dst = 1'b0;
        dec_dst     = '0;
        dec_load    = 1'b0;
        dec_illegal = 1'b0;
        case (dec_opcode)
            OP_RTYPE: begin
                dec_type    = TYPE_R;
                dec_use_rs  = 1'b1;
                dec_use_rt  = 1'b1;
                dec_has_dst = 1'b1;
                dec_dst     = dec_rd;
            end
            OP_J: begin
                dec_type = TYPE_J;
            end
            OP_HALT: begin
                dec_type = TYPE_HALT;
            end
            OP_ADDI, OP_ANDI: begin
                dec_use_rs  = 1'b1;
                dec_has_dst = 1'b1;
                dec_dst     = dec_rt;
            end
            OP_LW: begin
                dec_use_rs  = 1'b1;
                dec_has_dst = 1'b1;
                dec_dst     = dec_rt;
                dec_load    = 1'b1;
            end
            OP_SW, OP_BEQ, OP_BNE: begin
                dec_use_rs = 1'b1;
                dec_use_rt = 1'b1;
            end
            default: begin
                // Unknown opcode: flows through as a NOP, reads and writes nothing
                dec_illegal = 1'b1;
            end
        endcase
    end

    // A write to r0 is architecturally discarded, so it never enters the window
    assign dec_wb_en  = dec_has_dst && (dec_dst != '0);
    assign dec_wb_reg = dec_wb_en ? dec_dst : '0;

    // In-flight destination window, slot 0 is the instruction now held in the output register
    logic            slot_vld_p1 [HAZ_DEPTH];
    logic [RA_W-1:0] slot_reg_p1 [HAZ_DEPTH];
    logic            slot_ld_p1  [HAZ_DEPTH];

    logic       rs_hit;
    logic       rt_hit;
    logic [1:0] rs_sel;
    logic [1:0] rt_sel;
    logic       rs_ld;
    logic       rt_ld;
    logic       rs_blk;
    logic       rt_blk;
    logic       hazard;
    logic       advance;
    logic       accept;

    // Search the window from oldest to newest so the newest matching producer wins
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        rs_sel = 2'd0;
        rt_sel = 2'd0;
        rs_ld  = 1'b0;
        rt_ld  = 1'b0;
        for (int i = HAZ_DEPTH - 1; i >= 0; i--) begin
            if (slot_vld_p1[i] && dec_use_rs && (dec_rs != '0) && (slot_reg_p1[i] == dec_rs)) begin
                rs_hit = 1'b1;
                rs_sel = 2'(i + 1);
                rs_ld  = slot_ld_p1[i];
            end
            if (slot_vld_p1[i] && dec_use_rt && (dec_rt != '0) && (slot_reg_p1[i] == dec_rt)) begin
                rt_hit = 1'b1;
                rt_sel = 2'(i + 1);
                rt_ld  = slot_ld_p1[i];
            end
        end
    end

    // With forwarding only a load still sitting in slot 0 blocks (its data is not ready yet)
    assign rs_blk = rs_hit & (~FWD_EN | (rs_ld & (rs_sel == 2'd1)));
    assign rt_blk = rt_hit & (~FWD_EN | (rt_ld & (rt_sel == 2'd1)));
    assign hazard = rs_blk | rt_blk;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance & ~halted & ~hazard;
    assign accept   = in_valid & in_ready;
    assign stall    = in_valid & ~halted & hazard;

    // Age the window whenever the output register moves; a bubble enters as an invalid slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                slot_vld_p1[i] <= 1'b0;
                slot_ld_p1[i]  <= 1'b0;
            end
        end else if (advance) begin
            for (int i = HAZ_DEPTH - 1; i > 0; i--) begin
                slot_vld_p1[i] <= slot_vld_p1[i-1];
                slot_reg_p1[i] <= slot_reg_p1[i-1];
                slot_ld_p1[i]  <= slot_ld_p1[i-1];
            end
            slot_vld_p1[0] <= accept & dec_wb_en;
            slot_reg_p1[0] <= dec_wb_reg;
            slot_ld_p1[0]  <= accept & dec_wb_en & dec_load;
        end
    end

    // ---- decode -> EX output register boundary ----
    // Output register: load on acceptance, drop valid on a bubble, hold under backpressure
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_opcode  <= '0;
            out_type    <= '0;
            out_rs      <= '0;
            out_rt      <= '0;
            out_rd      <= '0;
            out_sa      <= '0;
            out_funct   <= '0;
            out_imm     <= '0;
            out_jaddr   <= '0;
            out_wb_en   <= 1'b0;
            out_wb_reg  <= '0;
            out_illegal <= 1'b0;
`ifdef ID_FORWARD_EN
            fwd_rs_sel  <= 2'd0;
            fwd_rt_sel  <= 2'd0;
`endif
        end else if (advance) begin
            out_valid <= accept;
            if (accept) begin
                out_opcode  <= dec_opcode;
                out_type    <= dec_type;
                out_rs      <= dec_rs;
                out_rt      <= dec_rt;
                out_rd      <= dec_rd;
                out_sa      <= in_instr[10:6];
                out_funct   <= in_instr[5:0];
                out_imm     <= in_instr[15:0];
                out_jaddr   <= in_instr[25:0];
                out_wb_en   <= dec_wb_en;
                out_wb_reg  <= dec_wb_reg;
                out_illegal <= dec_illegal;
`ifdef ID_FORWARD_EN
                fwd_rs_sel  <= rs_sel;
                fwd_rt_sel  <= rt_sel;
`endif
            end
        end
    end

`ifndef ID_FORWARD_EN
    assign fwd_rs_sel = 2'd0;
    assign fwd_rt_sel = 2'd0;
`endif

    // HALT is sticky until reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else if (accept && (dec_type == TYPE_HALT)) begin
            halted <= 1'b1;
        end
    end

endmodule
